// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-edge write-back bypass, load-use bubble
// insertion, execute back-pressure and branch flush.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_PR1,
  input  logic [ADDR_W-1:0] id_PR2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] id_WR,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [3:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              wb_write,
  input  logic [ADDR_W-1:0] wb_WR,
  input  logic [DATA_W-1:0] wb_WD,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_A,
  output logic [DATA_W-1:0] ex_B,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_WR,
  output logic [3:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic [CNT_W-1:0]  stall_count,
  output logic              dbg_state
);

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] wr;
    logic [3:0]        alu_op;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
  } ex_t;

  state_e            state_q, state_d;
  ex_t               ex_q, ex_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              hz;
  logic [DATA_W-1:0] op_a, op_b;

  // Valid/ready: ID/EX accepts a decode slot only on an edge with ex_ready=1;
  // decode must hold its instruction whenever id_stall=1.
  always_comb begin
    hz = ex_q.valid & ex_q.mem_read & id_valid &
         ((id_use1 & (id_PR1 == ex_q.wr)) | (id_use2 & (id_PR2 == ex_q.wr)));
    // reg_file writes on this same edge, so RD1/RD2 are still the old values
    op_a = (wb_write && (wb_WR == id_PR1)) ? wb_WD : RD1;
    op_b = (wb_write && (wb_WR == id_PR2)) ? wb_WD : RD2;
    id_stall = ~reset & ~flush & (~ex_ready | hz);
  end

  always_comb begin
    state_d       = state_q;
    ex_d          = ex_q;
    stall_count_d = stall_count_q;
    if (flush) begin
      ex_d    = '0;
      state_d = RUN;
    end else if (ex_ready) begin
      case (state_q)
        RUN:     state_d = hz ? BUBBLE : RUN;
        BUBBLE:  state_d = RUN;
        default: state_d = RUN;
      endcase
      if (hz) begin
        ex_d = '0;
        if (stall_count_q != {CNT_W{1'b1}}) stall_count_d = stall_count_q + 1'b1;
      end else begin
        ex_d.valid     = id_valid;
        ex_d.a         = op_a;
        ex_d.b         = op_b;
        ex_d.imm       = id_imm;
        ex_d.wr        = id_WR;
        ex_d.alu_op    = id_alu_op & {4{id_valid}};
        ex_d.alu_src   = id_alu_src & id_valid;
        ex_d.mem_read  = id_mem_read & id_valid;
        ex_d.mem_write = id_mem_write & id_valid;
        ex_d.reg_write = id_reg_write & id_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      ex_q          <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ex_q          <= ex_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_A         = ex_q.a;
  assign ex_B         = ex_q.b;
  assign ex_imm       = ex_q.imm;
  assign ex_WR        = ex_q.wr;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_alu_src   = ex_q.alu_src;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_reg_write = ex_q.reg_write;
  assign stall_count  = stall_count_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model of
// the pipeline-boundary rules; a narrow-counter instance exercises saturation.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [AW-1:0] wr;
    logic [3:0]    op;
    logic          src;
    logic          mr;
    logic          mw;
    logic          rw;
  } ex_t;

  // clock / reset
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, id_valid, id_use1, id_use2;
  logic [AW-1:0] id_PR1, id_PR2, id_WR, wb_WR;
  logic [DW-1:0] RD1, RD2, id_imm, wb_WD;
  logic [3:0]    id_alu_op;
  logic          id_alu_src, id_mem_read, id_mem_write, id_reg_write;
  logic          wb_write, ex_ready, flush;

  logic          id_stall, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, dbg_state;
  logic [DW-1:0] ex_A, ex_B, ex_imm;
  logic [AW-1:0] ex_WR;
  logic [3:0]    ex_alu_op;
  logic [15:0]   stall_count;

  logic          s_id_stall, s_ex_valid, s_ex_alu_src, s_ex_mem_read, s_ex_mem_write, s_ex_reg_write, s_dbg_state;
  logic [DW-1:0] s_ex_A, s_ex_B, s_ex_imm;
  logic [AW-1:0] s_ex_WR;
  logic [3:0]    s_ex_alu_op;
  logic [3:0]    s_stall_count;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_PR1(id_PR1), .id_PR2(id_PR2),
    .id_use1(id_use1), .id_use2(id_use2), .RD1(RD1), .RD2(RD2), .id_WR(id_WR),
    .id_imm(id_imm), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .wb_write(wb_write), .wb_WR(wb_WR), .wb_WD(wb_WD), .ex_ready(ex_ready), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_imm(ex_imm),
    .ex_WR(ex_WR), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .stall_count(stall_count), .dbg_state(dbg_state)
  );

  id_ex_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_PR1(id_PR1), .id_PR2(id_PR2),
    .id_use1(id_use1), .id_use2(id_use2), .RD1(RD1), .RD2(RD2), .id_WR(id_WR),
    .id_imm(id_imm), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .wb_write(wb_write), .wb_WR(wb_WR), .wb_WD(wb_WD), .ex_ready(ex_ready), .flush(flush),
    .id_stall(s_id_stall), .ex_valid(s_ex_valid), .ex_A(s_ex_A), .ex_B(s_ex_B), .ex_imm(s_ex_imm),
    .ex_WR(s_ex_WR), .ex_alu_op(s_ex_alu_op), .ex_alu_src(s_ex_alu_src),
    .ex_mem_read(s_ex_mem_read), .ex_mem_write(s_ex_mem_write), .ex_reg_write(s_ex_reg_write),
    .stall_count(s_stall_count), .dbg_state(s_dbg_state)
  );

  // scoreboard
  int  vec_cnt = 0;
  int  err_cnt = 0;
  ex_t exp_q[$];
  ex_t m;
  bit  m_data_ok, m_op_ok, m_bub;
  int  m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: check the combinational stall, advance the model, check ID/EX
  task automatic step();
    bit  hz, data_ok_n, op_ok_n, bub_n;
    int  cnt_n;
    ex_t n, e;
    #1;
    hz = m.valid && m.mr && id_valid &&
         ((id_use1 && id_PR1 == m.wr) || (id_use2 && id_PR2 == m.wr));
    check_eq("id_stall", {63'd0, id_stall}, {63'd0, !reset && !flush && (!ex_ready || hz)});
    n = m; data_ok_n = m_data_ok; op_ok_n = m_op_ok; bub_n = m_bub; cnt_n = m_cnt;
    if (reset) begin
      n = '0; data_ok_n = 1; op_ok_n = 1; bub_n = 0; cnt_n = 0;
    end else if (flush) begin
      n = '0; data_ok_n = 1; op_ok_n = 1; bub_n = 0;
    end else if (ex_ready) begin
      bub_n = m_bub ? 1'b0 : hz;
      if (hz) begin
        n.valid = 0; n.wr = 0; n.op = 0; n.src = 0; n.mr = 0; n.mw = 0; n.rw = 0;
        data_ok_n = 0; op_ok_n = 1;
        if (cnt_n < 65535) cnt_n++;
      end else begin
        n.valid = id_valid;
        n.a     = (wb_write && wb_WR == id_PR1) ? wb_WD : RD1;
        n.b     = (wb_write && wb_WR == id_PR2) ? wb_WD : RD2;
        n.imm   = id_imm;
        n.wr    = id_WR;
        n.op    = id_valid ? id_alu_op : 4'd0;
        n.src   = id_valid && id_alu_src;
        n.mr    = id_valid && id_mem_read;
        n.mw    = id_valid && id_mem_write;
        n.rw    = id_valid && id_reg_write;
        data_ok_n = 1; op_ok_n = id_valid;
      end
    end
    exp_q.push_back(n);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    m = e; m_data_ok = data_ok_n; m_op_ok = op_ok_n; m_bub = bub_n; m_cnt = cnt_n;
    check_eq("ex_valid", {63'd0, ex_valid}, {63'd0, e.valid});
    check_eq("ex_WR", {59'd0, ex_WR}, {59'd0, e.wr});
    check_eq("ex_ctl", {60'd0, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write},
             {60'd0, e.src, e.mr, e.mw, e.rw});
    if (m_op_ok) check_eq("ex_alu_op", {60'd0, ex_alu_op}, {60'd0, e.op});
    if (m_data_ok) begin
      check_eq("ex_A", {32'd0, ex_A}, {32'd0, e.a});
      check_eq("ex_B", {32'd0, ex_B}, {32'd0, e.b});
      check_eq("ex_imm", {32'd0, ex_imm}, {32'd0, e.imm});
    end
    check_eq("stall_count", {48'd0, stall_count}, 64'(m_cnt));
    check_eq("sat_count", {60'd0, s_stall_count}, 64'((m_cnt > 15) ? 15 : m_cnt));
    check_eq("fsm_state", {63'd0, dbg_state}, {63'd0, m_bub});
  endtask

  // driver tasks
  task automatic drive_idle();
    reset = 0; id_valid = 0; id_PR1 = 0; id_PR2 = 0; id_use1 = 0; id_use2 = 0;
    RD1 = 0; RD2 = 0; id_WR = 0; id_imm = 0; id_alu_op = 0; id_alu_src = 0;
    id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
    wb_write = 0; wb_WR = 0; wb_WD = 0; ex_ready = 1; flush = 0;
  endtask

  task automatic drive_load(input logic [AW-1:0] wr);
    drive_idle();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_WR = wr; id_alu_op = 4'd2;
  endtask

  task automatic drive_dep(input logic [AW-1:0] src2, input logic use2);
    drive_idle();
    id_valid = 1; id_PR2 = src2; id_use2 = use2; id_WR = 5'd9; id_reg_write = 1;
    RD2 = 32'h55;
  endtask

  task automatic drive_random();
    reset        = ($urandom_range(0, 99) < 2);
    flush        = ($urandom_range(0, 99) < 8);
    ex_ready     = ($urandom_range(0, 99) < 85);
    id_valid     = ($urandom_range(0, 99) < 85);
    id_PR1       = AW'($urandom_range(0, 3));
    id_PR2       = AW'($urandom_range(0, 3));
    id_use1      = 1'($urandom);
    id_use2      = 1'($urandom);
    RD1          = $urandom;
    RD2          = $urandom;
    id_WR        = AW'($urandom_range(0, 3));
    id_imm       = $urandom;
    id_alu_op    = 4'($urandom);
    id_alu_src   = 1'($urandom);
    id_mem_read  = ($urandom_range(0, 99) < 45);
    id_mem_write = 1'($urandom);
    id_reg_write = 1'($urandom);
    wb_write     = 1'($urandom);
    wb_WR        = AW'($urandom_range(0, 3));
    wb_WD        = $urandom;
  endtask

  initial begin
    m = '0; m_data_ok = 1; m_op_ok = 1; m_bub = 0; m_cnt = 0;
    drive_idle();
    reset = 1;
    @(posedge clk);
    step();
    check_eq("rst_valid", {63'd0, ex_valid}, 64'd0);

    // reset then load
    drive_idle();
    id_valid = 1; id_PR1 = 6; id_PR2 = 8; RD1 = 6; RD2 = 8; id_WR = 3; id_reg_write = 1;
    id_use1 = 1; id_use2 = 1;
    step();
    check_eq("tp_load_A", {32'd0, ex_A}, 64'd6);
    check_eq("tp_load_B", {32'd0, ex_B}, 64'd8);

    // write-back bypass and its absence
    wb_write = 1; wb_WR = 4; wb_WD = 31; id_PR1 = 4; RD1 = 4;
    step();
    check_eq("tp_bypass", {32'd0, ex_A}, 64'd31);
    wb_write = 0;
    step();
    check_eq("tp_no_bypass", {32'd0, ex_A}, 64'd4);

    // load-use: one bubble, then the dependent instruction
    drive_load(5);
    step();
    drive_dep(5, 1);
    step();
    check_eq("tp_bubble_cnt", {48'd0, stall_count}, 64'd1);
    step();
    check_eq("tp_dep_loaded", {63'd0, ex_valid}, 64'd1);
    drive_load(5);
    step();
    drive_dep(5, 0);
    step();
    check_eq("tp_no_hz_valid", {63'd0, ex_valid}, 64'd1);

    // back-pressure for 3 cycles while decode changes
    for (int i = 0; i < 3; i++) begin
      drive_random();
      reset = 0; flush = 0; ex_ready = 0;
      step();
    end

    // flush coincident with a hazard, then with back-pressure
    drive_load(7);
    step();
    drive_dep(7, 1);
    flush = 1;
    step();
    drive_load(7);
    step();
    drive_idle();
    ex_ready = 0; flush = 1;
    step();

    // saturation on the 4-bit instance, then reset while in BUBBLE
    for (int i = 0; i < 20; i++) begin
      drive_load(7);
      step();
      drive_dep(7, 1);
      step();
    end
    check_eq("tp_sat", {60'd0, s_stall_count}, 64'd15);
    drive_idle();
    reset = 1;
    step();
    check_eq("tp_rst_bubble", {48'd0, stall_count}, 64'd0);

    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline boundary that sits directly downstream of `reg_file`. It captures the operand pair read from `RD1`/`RD2`, together with decode control fields, into the ID/EX register. It bypasses a same-edge write-back so that stale reads are never latched, and detects load-use hazards by inserting a one-cycle bubble and stalling decode. It also honours execute-side back-pressure and a branch flush.

## Interface
- `DATA_W`, 32, operand / write-data width
- `ADDR_W`, 5, register index width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; one clock, sampled on the rising edge of `clk`
- `id_valid`  in  1  decode holds a valid instruction
- `id_PR1`, `id_PR2`  in  ADDR_W  source indices (same values driven to `reg_file` PR1/PR2)
- `id_use1`, `id_use2`  in  1  instruction actually reads source 1 / 2
- `RD1`, `RD2`  in  DATA_W  combinational read data from `reg_file`
- `id_WR`  in  ADDR_W  destination index
- `id_imm`  in  DATA_W  sign-extended immediate
- `id_alu_op`  in  4  ALU opcode
- `id_alu_src`, `id_mem_read`, `id_mem_write`, `id_reg_write`  in  1  control bits
- `wb_write`, `wb_WR`, `wb_WD`  in  1/ADDR_W/DATA_W  write-back port (same nets as `reg_file` write/WR/WD)
- `ex_ready`  in  1  execute stage can accept a new instruction this edge
- `flush`  in  1  branch resolved taken; kill the instruction entering ID/EX
- `id_stall`  out  1  combinational; decode must hold its current instruction
- `ex_valid`  out  1  registered; ID/EX holds a real instruction
- `ex_A`, `ex_B`, `ex_imm`  out  DATA_W  registered operands / immediate
- `ex_WR`  out  ADDR_W  registered destination
- `ex_alu_op`, `ex_alu_src`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write`  out  registered control
- `stall_count`  out  16  saturating count of load-use bubbles inserted

## Operation
- Hazard (combinational): `hz = ex_valid & ex_mem_read & id_valid & ((id_use1 & id_PR1==ex_WR) | (id_use2 & id_PR2==ex_WR))`. Register 0 gets no special case; it is writable in `reg_file`.
- Bypass: `opA = (wb_write & wb_WR==id_PR1) ? wb_WD : RD1`. `opB` is formed the same way from `id_PR2` and `RD2`. Bypass applies only at the capture edge.
- FSM states: RUN and BUBBLE.
  - RUN → BUBBLE when `hz & ex_ready & ~flush`.
  - BUBBLE → RUN unconditionally on the next edge that has `ex_ready=1`.
  - While `ex_ready=0` the FSM holds its state.
- Edge action priority, highest first:
  1. `reset`: all outputs 0, FSM = RUN, `stall_count` = 0.
  2. `flush`: `ex_valid`←0, all control fields←0, FSM←RUN; data fields don't-care (cleared to 0).
  3. `~ex_ready`: hold every ID/EX field unchanged.
  4. `hz`: insert bubble (`ex_valid`←0, control←0, `ex_WR`←0); `stall_count`←`stall_count+1` (saturates at 16'hFFFF).
  5. Otherwise load: `ex_valid`←`id_valid`; operands←`opA`/`opB`; remaining fields←`id_*`. Control bits are ANDed with `id_valid`.
- `id_stall = ~reset & ~flush & (~ex_ready | hz)`.

## Timing
- Latency: decode fields to `ex_*` is exactly one rising edge.
- Reset values: every `ex_*` output is 0, `ex_valid`=0, `stall_count`=0, `id_stall`=0 while `reset`=1.
- Load-use costs exactly one bubble cycle. On the following edge the load has left ID/EX, `hz` drops, and the dependent instruction loads. The execute/memory stage forwards the load result; that forwarding is outside this block.
- Same-edge write-back: `reg_file` updates on the same rising edge, so `RD1`/`RD2` are still stale. The bypass guarantees the captured value equals `wb_WD`.
- `flush` coincident with `hz`: flush wins, no bubble is counted, and `id_stall`=0.
- `flush` coincident with `~ex_ready`: flush wins and ID/EX is cleared.
- `reset` asserted mid-stall or in BUBBLE: the next edge returns the block to reset state.
- `ex_ready=0` with `hz=1`: hold; `stall_count` is not incremented until the bubble is actually inserted.

## Test plan
- Reset then load: reset 1 cycle; `id_valid`=1, PR1=6, PR2=8, RD1=6, RD2=8, `id_WR`=3, `id_reg_write`=1 → one edge later `ex_valid`=1, `ex_A`=6, `ex_B`=8, `ex_WR`=3, `ex_reg_write`=1.
- WB bypass: `wb_write`=1, `wb_WR`=4, `wb_WD`=31, `id_PR1`=4, RD1=4 (stale) → `ex_A`=31. Repeat with `wb_write`=0 → `ex_A`=4.
- Load-use:
  - Stimulus: load with `id_mem_read`=1, WR=5, followed by an instruction with PR2=5, `id_use2`=1.
  - Required: `id_stall`=1 for one cycle; next edge `ex_valid`=0 and `stall_count`=1; the edge after that loads the dependent instruction with `ex_valid`=1.
  - Also required: same sequence with `id_use2`=0 → no stall.
- Back-pressure: `ex_ready`=0 for 3 cycles while decode changes → `ex_*` frozen at prior values, `id_stall`=1 throughout, `stall_count` unchanged.
- Flush priority:
  - `flush`=1 coincident with `hz`=1 → `ex_valid`=0, `stall_count` unchanged, `id_stall`=0.
  - `flush`=1 with `ex_ready`=0 → ID/EX cleared.
- Saturation and reset: force 65536 bubbles → `stall_count` stays at 65535. Assert `reset` while in BUBBLE → all outputs 0 next edge.
